// File: rtl/kb_pkg.sv
// Register map, bit positions and status layout for the keyboard scancode FIFO.
// Shared by keyboard_fifo_mmio and anything that decodes its register window.
package kb_pkg;

    // Word offsets within the register window (cpu_addr_in[3:2])
    localparam logic [1:0] KB_OFF_DATA   = 2'd0;
    localparam logic [1:0] KB_OFF_STATUS = 2'd1;
    localparam logic [1:0] KB_OFF_CTRL   = 2'd2;

    // DATA register
    localparam int unsigned KB_DATA_VALID  = 31;

    // STATUS register
    localparam int unsigned KB_ST_NONEMPTY = 0;
    localparam int unsigned KB_ST_FULL     = 1;
    localparam int unsigned KB_ST_OVF      = 2;

    // CTRL register
    localparam int unsigned KB_CTRL_FLUSH  = 0;
    localparam int unsigned KB_CTRL_IRQ_EN = 1;

    // STATUS read layout
    typedef struct packed {
        logic [7:0]  rsvd_hi;
        logic [7:0]  count;
        logic [12:0] rsvd_lo;
        logic        overflow;
        logic        full;
        logic        nonempty;
    } kb_status_t;

endpackage

// File: rtl/kb_sync_fifo.sv
// Single-clock ring-buffer FIFO with distributed (LUT) storage.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   push, din        enqueue din (ignored when full unless popping the same cycle)
//   pop              dequeue head (ignored when empty)
//   flush            empty the FIFO; overrides push and pop
//   dout             head entry, combinational
//   count            occupancy, 0..DEPTH
//   full, empty      registered occupancy flags
module kb_sync_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    // Accepted operations; a pop frees a slot for a same-cycle push
    always_comb begin
        do_pop    = pop && !empty && !flush;
        do_push   = push && !flush && (!full || do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            count_nxt = '0;
        end
    end

    // Storage has no reset; contents are don't-care until written
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

    // Pointers, occupancy and flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/keyboard_fifo_mmio.sv
// PS/2 scancode FIFO exposed to the CPU as a small MMIO register window.
// DATA pops one code per read, STATUS reports occupancy/full/overflow (overflow
// is W1C), CTRL provides a self-clearing flush and, with KB_IRQ_EN defined,
// an interrupt enable driving a registered level interrupt.
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   kb_scancode_in        scancode from ps2_rx
//   kb_valid_in           one-cycle strobe pushing kb_scancode_in
//   cpu_addr_in           byte address; [19:16] selects the block, [3:2] the register
//   cpu_read_in           read strobe
//   cpu_write_enable_in   byte write enables; only lane 0 qualifies a write
//   cpu_data_in           write data
//   cpu_data_out          registered read data, valid the edge after cpu_read_in
//   irq_out               level interrupt (0 unless KB_IRQ_EN is defined)
module keyboard_fifo_mmio
    import kb_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned CODE_WIDTH = 8,
    parameter logic [3:0]  REGION     = 4'h3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [CODE_WIDTH-1:0] kb_scancode_in,
    input  logic                  kb_valid_in,
    input  logic [31:0]           cpu_addr_in,
    input  logic                  cpu_read_in,
    input  logic [3:0]            cpu_write_enable_in,
    input  logic [31:0]           cpu_data_in,
    output logic [31:0]           cpu_data_out,
    output logic                  irq_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  hit;
    logic [1:0]            off;
    logic                  wr_en;
    logic                  rd_en;
    logic                  flush;
    logic                  pop;
    logic                  ovf_set;
    logic                  ovf_clr;
    logic                  overflow;
    logic                  irq_en;
    logic [CODE_WIDTH-1:0] head;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    kb_status_t            status;
    logic [31:0]           rdata;
    logic                  unused_bits;

    // Address decode and strobe qualification
    always_comb begin
        hit     = (cpu_addr_in[19:16] == REGION);
        off     = cpu_addr_in[3:2];
        wr_en   = hit && cpu_write_enable_in[0];
        rd_en   = hit && cpu_read_in;
        flush   = wr_en && (off == KB_OFF_CTRL) && cpu_data_in[KB_CTRL_FLUSH];
        pop     = rd_en && (off == KB_OFF_DATA) && !empty;
        // A push into a full FIFO is lost unless a pop frees a slot or a flush drops it
        ovf_set = kb_valid_in && !flush && full && !pop;
        ovf_clr = wr_en && (off == KB_OFF_STATUS) && cpu_data_in[KB_ST_OVF];
    end

    kb_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_WIDTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (kb_valid_in),
        .pop    (pop),
        .flush  (flush),
        .din    (kb_scancode_in),
        .dout   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Sticky overflow; a same-cycle set beats the W1C clear
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (overflow && !ovf_clr) || ovf_set;
        end
    end

    // Read data mux, sampled from state before this cycle's push/pop
    always_comb begin
        status          = '0;
        status.count    = 8'(count);
        status.overflow = overflow;
        status.full     = full;
        status.nonempty = !empty;
        rdata           = '0;
        case (off)
            KB_OFF_DATA: begin
                if (!empty) begin
                    rdata                = 32'(head);
                    rdata[KB_DATA_VALID] = 1'b1;
                end
            end
            KB_OFF_STATUS: rdata = status;
            KB_OFF_CTRL:   rdata[KB_CTRL_IRQ_EN] = irq_en;
            default:       rdata = '0;
        endcase
    end

    // Read data register holds between reads; a miss returns zero
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_data_out <= '0;
        end else if (cpu_read_in) begin
            cpu_data_out <= hit ? rdata : '0;
        end
    end

`ifdef KB_IRQ_EN
    // Interrupt enable and registered level interrupt
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            irq_en  <= 1'b0;
            irq_out <= 1'b0;
        end else begin
            if (wr_en && (off == KB_OFF_CTRL)) begin
                irq_en <= cpu_data_in[KB_CTRL_IRQ_EN];
            end
            irq_out <= irq_en && (!empty || overflow);
        end
    end
`else
    assign irq_en  = 1'b0;
    assign irq_out = 1'b0;
`endif

    // Bus bits this block does not decode
    assign unused_bits = ^{cpu_addr_in[31:20], cpu_addr_in[15:4], cpu_addr_in[1:0],
                           cpu_write_enable_in[3:1], cpu_data_in[31:3], cpu_data_in[1]};

endmodule

// File: tb/tb_keyboard_fifo_mmio.sv
// Scoreboard bench for keyboard_fifo_mmio: directed sequences then random
// traffic, checked against a queue-based reference model of the register map.
module tb_keyboard_fifo_mmio;

    localparam int TB_DEPTH = 4;

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  kb_scancode_in;
    logic        kb_valid_in;
    logic [31:0] cpu_addr_in;
    logic        cpu_read_in;
    logic [3:0]  cpu_write_enable_in;
    logic [31:0] cpu_data_in;
    logic [31:0] cpu_data_out;
    logic        irq_out;

    keyboard_fifo_mmio #(
        .DEPTH      (TB_DEPTH),
        .CODE_WIDTH (8),
        .REGION     (4'h3)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .kb_scancode_in      (kb_scancode_in),
        .kb_valid_in         (kb_valid_in),
        .cpu_addr_in         (cpu_addr_in),
        .cpu_read_in         (cpu_read_in),
        .cpu_write_enable_in (cpu_write_enable_in),
        .cpu_data_in         (cpu_data_in),
        .cpu_data_out        (cpu_data_out),
        .irq_out             (irq_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_irq_en;
    int         n_pass;
    int         n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] addr_hit(input logic [1:0] off);
        logic [11:0] hi;
        logic [11:0] mid;
        logic [1:0]  lo;
        hi  = 12'($urandom);
        mid = 12'($urandom);
        lo  = 2'($urandom);
        return {hi, 4'h3, mid, off, lo};
    endfunction

    function automatic logic [31:0] addr_miss(input logic [1:0] off);
        logic [3:0] reg_sel;
        reg_sel = 4'($urandom_range(4, 15));
        return {12'h0, reg_sel, 12'h0, off, 2'b00};
    endfunction

    // One bus cycle: drive inputs, advance the model, queue the expected read result
    task automatic cyc(input bit kv, input logic [7:0] code, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wd);
        bit   hit;
        int   off;
        bit   pop;
        bit   flush;
        bit   set;
        bit   clr;
        exp_t e;
        @(negedge clk_in);
        kb_valid_in         = kv;
        kb_scancode_in      = code;
        cpu_read_in         = rd;
        cpu_write_enable_in = wr ? 4'b0001 : 4'b0000;
        cpu_addr_in         = addr;
        cpu_data_in         = wd;

        hit    = (addr[19:16] == 4'h3);
        off    = int'(addr[3:2]);
        e.irq  = 1'b0;
`ifdef KB_IRQ_EN
        e.irq  = m_irq_en && (mq.size() != 0 || m_ovf);
`endif
        e.data = 32'h0;
        if (rd && hit) begin
            case (off)
                0: if (mq.size() != 0) e.data = 32'h8000_0000 | {24'h0, mq[0]};
                1: e.data = {8'h0, 8'(mq.size()), 13'h0, m_ovf, mq.size() == TB_DEPTH, mq.size() != 0};
                2: e.data = {30'h0, m_irq_en, 1'b0};
                default: e.data = 32'h0;
            endcase
        end

        pop   = rd && hit && off == 0 && mq.size() != 0;
        flush = wr && hit && off == 2 && wd[0];
        clr   = wr && hit && off == 1 && wd[2];
        set   = 1'b0;
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (kv) begin
            if (mq.size() < TB_DEPTH) mq.push_back(code);
            else set = 1'b1;
        end
        m_ovf = (m_ovf && !clr) || set;
`ifdef KB_IRQ_EN
        if (wr && hit && off == 2) m_irq_en = wd[1];
`endif
        if (rd) sb.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic push(input logic [7:0] code);
        cyc(1'b1, code, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] off);
        cyc(1'b0, 8'h0, 1'b1, 1'b0, addr_hit(off), 32'h0);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        cyc(1'b0, 8'h0, 1'b0, 1'b1, addr_hit(off), data);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in              = 1'b1;
        kb_valid_in         = 1'b0;
        cpu_read_in         = 1'b0;
        cpu_write_enable_in = 4'h0;
        repeat (2) @(negedge clk_in);
        mq.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        check("reset_rdata", cpu_data_out, 32'h0);
        check("reset_irq", {31'h0, irq_out}, 32'h0);
        rst_in = 1'b0;
    endtask

    // Monitor: every read strobe taken outside reset yields one registered result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            if (!rst_in && cpu_read_in) begin
                #1;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got read with no expectation, required none");
                end else begin
                    e = sb.pop_front();
                    check("rdata", cpu_data_out, e.data);
                    check("irq", {31'h0, irq_out}, {31'h0, e.irq});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    initial begin
        int         r;
        bit         kv;
        logic [7:0] code;
        n_pass = 0;
        n_total = 0;
        m_ovf = 1'b0;
        m_irq_en = 1'b0;
        rst_in = 1'b1;
        kb_valid_in = 1'b0;
        kb_scancode_in = 8'h0;
        cpu_addr_in = 32'h0;
        cpu_read_in = 1'b0;
        cpu_write_enable_in = 4'h0;
        cpu_data_in = 32'h0;
        do_reset();
        rd(2'd1);

        // Basic ordering and empty read
        push(8'h1C); push(8'h32); push(8'h21);
        rd(2'd0); rd(2'd0); rd(2'd0); rd(2'd0);

        // Overflow and W1C
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        rd(2'd1);
        wr(2'd1, 32'h4);
        rd(2'd1);

        // Full FIFO, push coincident with DATA read
        cyc(1'b1, 8'h77, 1'b1, 1'b0, addr_hit(2'd0), 32'h0);
        rd(2'd1);

        // Flush with a concurrent push
        wr(2'd1, 32'h4);
        cyc(1'b1, 8'h99, 1'b0, 1'b1, addr_hit(2'd2), 32'h1);
        rd(2'd1); rd(2'd0);

        // Offset 3, CTRL, miss
        push(8'h5A);
        rd(2'd3); rd(2'd2);
        cyc(1'b0, 8'h0, 1'b1, 1'b0, addr_miss(2'd0), 32'h0);
        cyc(1'b0, 8'h0, 1'b0, 1'b1, addr_miss(2'd2), 32'h1);
        rd(2'd1); rd(2'd0);

        // Interrupt enable
        wr(2'd2, 32'h2);
        push(8'h11);
        rd(2'd2); rd(2'd0); rd(2'd1); idle();

        // Streaming push with a read every cycle, wrapping the pointers
        for (int i = 0; i < 200; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, addr_hit(2'd0), 32'h0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r    = int'($urandom_range(0, 99));
            kv   = ($urandom_range(0, 99) < 45);
            code = 8'($urandom);
            if      (r < 40) cyc(kv, code, 1'b1, 1'b0, addr_hit(2'd0), 32'h0);
            else if (r < 48) cyc(kv, code, 1'b1, 1'b0, addr_hit(2'd1), 32'h0);
            else if (r < 51) cyc(kv, code, 1'b1, 1'b0, addr_hit(2'd2), 32'h0);
            else if (r < 53) cyc(kv, code, 1'b1, 1'b0, addr_hit(2'd3), 32'h0);
            else if (r < 56) cyc(kv, code, 1'b1, 1'b0, addr_miss(2'd0), 32'h0);
            else if (r < 59) cyc(kv, code, 1'b0, 1'b1, addr_hit(2'd2), $urandom);
            else if (r < 64) cyc(kv, code, 1'b0, 1'b1, addr_hit(2'd1), $urandom);
            else if (r < 66) cyc(kv, code, 1'b0, 1'b1, addr_miss(2'd2), 32'hFFFF_FFFF);
            else             cyc(kv, code, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        idle();

        // Reset with codes queued
        push(8'hA1); push(8'hA2);
        do_reset();
        rd(2'd1); rd(2'd0); rd(2'd2);
        idle(); idle();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
